// File: rtl/vram_scan_arbiter_if.sv
// rtl/vram_scan_arbiter_if.sv - scan, writer, clear and RAM signal bundle of the VRAM arbiter
interface vram_scan_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12
);
    logic              p_tick;
    logic              video_on;
    logic [9:0]        x;
    logic [9:0]        y;
    logic              hsync_in;
    logic              vsync_in;
    logic              hsync;
    logic              vsync;
    logic [DATA_W-1:0] rgb;
    logic              w0_req;
    logic [ADDR_W-1:0] w0_addr;
    logic [DATA_W-1:0] w0_data;
    logic              w0_gnt;
    logic              w1_req;
    logic [ADDR_W-1:0] w1_addr;
    logic [DATA_W-1:0] w1_data;
    logic              w1_gnt;
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic              clr_done;
    logic              oob_err;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  p_tick, video_on, x, y, hsync_in, vsync_in,
        input  w0_req, w0_addr, w0_data, w1_req, w1_addr, w1_data,
        input  clr_start, clr_color, ram_rdata,
        output hsync, vsync, rgb, w0_gnt, w1_gnt, clr_busy, clr_done, oob_err,
        output ram_addr, ram_we, ram_wdata
    );

    modport master (
        output p_tick, video_on, x, y, hsync_in, vsync_in,
        output w0_req, w0_addr, w0_data, w1_req, w1_addr, w1_data,
        output clr_start, clr_color, ram_rdata,
        input  hsync, vsync, rgb, w0_gnt, w1_gnt, clr_busy, clr_done, oob_err,
        input  ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/vram_scan_arbiter.sv
// rtl/vram_scan_arbiter.sv - single-port VRAM sharing: scan-out, two round-robin writers, clear engine
module vram_scan_arbiter #(
    parameter int H_CELLS     = 160,
    parameter int V_CELLS     = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 12
) (
    input  logic                clk,
    input  logic                reset,
    vram_scan_arbiter_if.slave  bus
);
    localparam int                CELLS = H_CELLS * V_CELLS;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(CELLS - 1);

    typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;
    clr_state_t state, state_next;

    logic              rr_ptr;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_col;
    logic              clr_done_q;
    logic              oob_q;
    logic              disp_v, blank_v, hs1, vs1;
    logic              hs2, vs2;
    logic [DATA_W-1:0] rgb_q;

    logic              disp_slot, any_req, sel_w1, wr_slot, clr_slot, clr_last, wr_oob;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [19:0]       disp_full;

    assign disp_full = 20'(bus.y >> SCALE_SHIFT) * 20'(H_CELLS) + 20'(bus.x >> SCALE_SHIFT);

    // Slot decode: display beats writers, writers beat the clear engine.
    always_comb begin
        disp_slot     = bus.p_tick & bus.video_on;
        any_req       = bus.w0_req | bus.w1_req;
        sel_w1        = (bus.w0_req & bus.w1_req) ? rr_ptr : bus.w1_req;
        wr_slot       = !reset && !disp_slot && any_req;
        clr_slot      = !reset && !disp_slot && !any_req && (state == CLR_RUN);
        clr_last      = clr_slot && (clr_addr == LAST);
        wr_addr       = sel_w1 ? bus.w1_addr : bus.w0_addr;
        wr_data       = sel_w1 ? bus.w1_data : bus.w0_data;
        wr_oob        = 32'(wr_addr) >= CELLS;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        bus.ram_we    = 1'b0;
        if (disp_slot) begin
            bus.ram_addr = disp_full[ADDR_W-1:0];
        end else if (wr_slot) begin
            bus.ram_addr  = wr_addr;
            bus.ram_wdata = wr_data;
            bus.ram_we    = !wr_oob;
        end else if (clr_slot) begin
            bus.ram_addr  = clr_addr;
            bus.ram_wdata = clr_col;
            bus.ram_we    = 1'b1;
        end
        bus.w0_gnt = wr_slot & !sel_w1;
        bus.w1_gnt = wr_slot & sel_w1;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= CLR_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            CLR_IDLE: if (bus.clr_start) state_next = CLR_RUN;
            CLR_RUN:  if (clr_last)      state_next = CLR_IDLE;
            default:  state_next = CLR_IDLE;
        endcase
    end

    always_comb begin
        bus.clr_busy = (state == CLR_RUN);
        bus.clr_done = clr_done_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= 1'b0;
            clr_addr   <= '0;
            clr_col    <= '0;
            clr_done_q <= 1'b0;
            oob_q      <= 1'b0;
            disp_v     <= 1'b0;
            blank_v    <= 1'b0;
            hs1        <= 1'b0;
            vs1        <= 1'b0;
            hs2        <= 1'b0;
            vs2        <= 1'b0;
            rgb_q      <= '0;
        end else begin
            clr_done_q <= clr_last;
            if (state == CLR_IDLE && bus.clr_start) begin
                clr_col  <= bus.clr_color;
                clr_addr <= '0;
            end else if (clr_slot && !clr_last) begin
                clr_addr <= clr_addr + 1'b1;
            end
            if (wr_slot) rr_ptr <= !sel_w1;
            if (wr_slot && wr_oob) oob_q <= 1'b1;
            // RAM data arrives one clock after the display address; capture it one stage later.
            disp_v  <= disp_slot;
            blank_v <= bus.p_tick & !bus.video_on;
            hs1     <= bus.hsync_in;
            vs1     <= bus.vsync_in;
            hs2     <= hs1;
            vs2     <= vs1;
            if (disp_v)       rgb_q <= bus.ram_rdata;
            else if (blank_v) rgb_q <= '0;
        end
    end

    assign bus.oob_err = oob_q;
    assign bus.hsync   = hs2;
    assign bus.vsync   = vs2;
    assign bus.rgb     = rgb_q;
endmodule

// File: tb/tb_vram_scan_arbiter.sv
// tb/tb_vram_scan_arbiter.sv - directed self-checking bench for vram_scan_arbiter
module tb_vram_scan_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    vram_scan_arbiter_if bus ();

    vram_scan_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Clear-write monitor: every write not granted to a writer must be the next clear cell.
    logic mon_en = 1'b0;
    int   clr_exp = 0;
    int   clr_writes = 0;
    int   clr_bad = 0;
    int   done_cnt = 0;
    logic [11:0] clr_exp_col = 12'h00F;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.ram_we && !bus.w0_gnt && !bus.w1_gnt) begin
                if (int'(bus.ram_addr) != clr_exp || bus.ram_wdata != clr_exp_col) clr_bad++;
                clr_exp++;
                clr_writes++;
            end
            if (bus.clr_done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic exp_ptr;
    logic ok;

    initial begin
        bus.p_tick = 0; bus.video_on = 0; bus.x = '0; bus.y = '0;
        bus.hsync_in = 0; bus.vsync_in = 0;
        bus.w0_req = 0; bus.w0_addr = '0; bus.w0_data = '0;
        bus.w1_req = 0; bus.w1_addr = '0; bus.w1_data = '0;
        bus.clr_start = 0; bus.clr_color = '0; bus.ram_rdata = '0;

        // 1. reset state, then reset mid-activity
        cyc(); cyc();
        reset = 0;
        cyc(); settle();
        check("rst_rgb", 32'(bus.rgb), 0);
        check("rst_busy", 32'(bus.clr_busy), 0);
        check("rst_oob", 32'(bus.oob_err), 0);
        check("rst_hsync", 32'(bus.hsync), 0);
        bus.clr_start = 1; bus.clr_color = 12'h123;
        bus.w0_req = 1; bus.w0_addr = 15'd3; bus.w0_data = 12'h456;
        settle();
        check("act_gnt0", 32'(bus.w0_gnt), 1);
        cyc();
        bus.clr_start = 0;
        reset = 1;
        settle();
        check("inrst_gnt0", 32'(bus.w0_gnt), 0);
        check("inrst_we", 32'(bus.ram_we), 0);
        cyc(); cyc();
        reset = 0; bus.w0_req = 0;
        settle();
        check("postrst_busy", 32'(bus.clr_busy), 0);
        check("postrst_we", 32'(bus.ram_we), 0);
        check("postrst_rgb", 32'(bus.rgb), 0);
        check("postrst_oob", 32'(bus.oob_err), 0);

        // 2. display read and blank tick
        cyc();
        bus.p_tick = 1; bus.video_on = 1; bus.x = 10'd8; bus.y = 10'd4; bus.hsync_in = 1;
        settle();
        check("disp_addr", 32'(bus.ram_addr), 162);
        check("disp_we", 32'(bus.ram_we), 0);
        cyc();
        bus.p_tick = 0; bus.hsync_in = 0; bus.ram_rdata = 12'hF0A;
        settle();
        check("hsync_d1", 32'(bus.hsync), 0);
        cyc(); settle();
        check("disp_rgb", 32'(bus.rgb), 32'h0F0A);
        check("hsync_d2", 32'(bus.hsync), 1);
        cyc(); settle();
        check("rgb_hold", 32'(bus.rgb), 32'h0F0A);
        check("hsync_d3", 32'(bus.hsync), 0);
        bus.p_tick = 1; bus.video_on = 0;
        cyc();
        bus.p_tick = 0;
        cyc(); settle();
        check("blank_rgb", 32'(bus.rgb), 0);

        // 3. contention with display ticks every 4th clock
        bus.x = '0; bus.y = '0; bus.video_on = 1;
        bus.w0_req = 1; bus.w0_addr = 15'd100; bus.w0_data = 12'h111;
        bus.w1_req = 1; bus.w1_addr = 15'd200; bus.w1_data = 12'h222;
        exp_ptr = 0;
        for (int i = 0; i < 12; i++) begin
            bus.p_tick = (i % 4 == 0);
            settle();
            if (i % 4 == 0) begin
                check("ct_tick_gnt", {30'd0, bus.w1_gnt, bus.w0_gnt}, 0);
                check("ct_tick_we", 32'(bus.ram_we), 0);
            end else begin
                check("ct_gnt", {30'd0, bus.w1_gnt, bus.w0_gnt}, exp_ptr ? 2 : 1);
                check("ct_we", 32'(bus.ram_we), 1);
                check("ct_addr", 32'(bus.ram_addr), exp_ptr ? 200 : 100);
                check("ct_data", 32'(bus.ram_wdata), exp_ptr ? 32'h222 : 32'h111);
                exp_ptr = ~exp_ptr;
            end
            cyc();
        end
        bus.p_tick = 0; bus.video_on = 0; bus.w0_req = 0; bus.w1_req = 0;

        // 4. out-of-range write and the last valid cell
        cyc(); settle();
        check("oob_pre", 32'(bus.oob_err), 0);
        bus.w1_req = 1; bus.w1_addr = 15'd19200; bus.w1_data = 12'h777;
        settle();
        check("oob_gnt", 32'(bus.w1_gnt), 1);
        check("oob_we", 32'(bus.ram_we), 0);
        cyc();
        bus.w1_addr = 15'd19199;
        settle();
        check("oob_set", 32'(bus.oob_err), 1);
        check("last_we", 32'(bus.ram_we), 1);
        cyc();
        bus.w1_req = 0;
        cyc(); cyc(); settle();
        check("oob_sticky", 32'(bus.oob_err), 1);

        // 5. full clear with a preempting writer and an ignored restart
        clr_exp = 0; clr_writes = 0; clr_bad = 0; done_cnt = 0; clr_exp_col = 12'h00F;
        mon_en = 1;
        bus.clr_start = 1; bus.clr_color = 12'h00F;
        cyc();
        bus.clr_start = 0;
        settle();
        check("clr_busy", 32'(bus.clr_busy), 1);
        for (int i = 0; i < 100; i++) cyc();
        bus.p_tick = 1; bus.video_on = 1;
        bus.w0_req = 1; bus.w0_addr = 15'd5; bus.w0_data = 12'hABC;
        settle();
        check("pre_tick_gnt", 32'(bus.w0_gnt), 0);
        check("pre_tick_we", 32'(bus.ram_we), 0);
        cyc();
        bus.p_tick = 0; bus.video_on = 0;
        settle();
        check("pre_gnt", 32'(bus.w0_gnt), 1);
        check("pre_addr", 32'(bus.ram_addr), 5);
        check("pre_data", 32'(bus.ram_wdata), 32'hABC);
        cyc();
        bus.w0_req = 0; bus.clr_start = 1; bus.clr_color = 12'hFFF;
        cyc();
        bus.clr_start = 0;
        ok = 0;
        for (int i = 0; i < 25000 && !ok; i++) begin
            cyc(); settle();
            if (bus.clr_done) ok = 1;
        end
        check("clr_done_seen", 32'(ok), 1);
        check("done_busy", 32'(bus.clr_busy), 0);
        cyc(); cyc();
        check("clr_writes", 32'(clr_writes), 19200);
        check("clr_seq_bad", 32'(clr_bad), 0);
        check("clr_done_cnt", 32'(done_cnt), 1);
        mon_en = 0;

        // 6. reset aborts a clear part way; restart begins at cell 0
        clr_exp = 0; clr_writes = 0; clr_bad = 0; done_cnt = 0;
        mon_en = 1;
        bus.clr_start = 1; bus.clr_color = 12'h00F;
        cyc();
        bus.clr_start = 0;
        for (int i = 0; i < 6000 && clr_writes < 5000; i++) cyc();
        check("abort_reach", 32'(clr_writes >= 5000), 1);
        reset = 1;
        settle();
        check("abort_we", 32'(bus.ram_we), 0);
        cyc(); cyc();
        reset = 0;
        settle();
        check("abort_busy", 32'(bus.clr_busy), 0);
        for (int i = 0; i < 300; i++) cyc();
        check("abort_busy_late", 32'(bus.clr_busy), 0);
        check("abort_no_done", 32'(done_cnt), 0);
        mon_en = 0;
        bus.clr_start = 1; bus.clr_color = 12'h0F0;
        cyc();
        bus.clr_start = 0;
        settle();
        check("restart_addr", 32'(bus.ram_addr), 0);
        check("restart_we", 32'(bus.ram_we), 1);
        check("restart_data", 32'(bus.ram_wdata), 32'h0F0);
        cyc(); settle();
        check("restart_next", 32'(bus.ram_addr), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
